// File: rtl/serial_eq_pkg.sv
// serial_eq_pkg: shared state encoding and default frame length for serial_eq_checker
package serial_eq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
  localparam int FRAME_LEN_DEF = 8;
endpackage

// File: rtl/xnor_gatelevel_gate.sv
// xnor_gatelevel_gate: gate-level XNOR cell, y = (~a & ~b) | (a & b)
module xnor_gatelevel_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  logic na, nb, both_lo, both_hi;
  not g_na (na, a_i);
  not g_nb (nb, b_i);
  and g_lo (both_lo, na, nb);
  and g_hi (both_hi, a_i, b_i);
  or  g_y  (y_o, both_lo, both_hi);
endmodule

// File: rtl/serial_eq_checker.sv
// serial_eq_checker: bit-serial frame comparator; SERIAL_EQ_EARLY_ABORT_EN ends a frame on its first mismatch
module serial_eq_checker
  import serial_eq_pkg::*;
#(
  parameter  int FRAME_LEN = FRAME_LEN_DEF,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_a,
  input  logic             bit_b,
  output logic             bit_ready,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_idx
);
  localparam logic [CNT_W-1:0] FL_C   = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_LEN - 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, idx_q, idx_d, mm_q, mm_d;
  logic             eq_q, eq_d, m, fin;
  xnor_gatelevel_gate u_xnor (
    .a_i(bit_a),
    .b_i(bit_b),
    .y_o(m)
  );
  assign bit_ready    = state_q == RUN;
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE;
  assign equal        = eq_q;
  assign match_cnt    = cnt_q;
  assign mismatch_idx = mm_q;
  // Next state and result updates; equal is settled on the final beat so it is valid alongside done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mm_d    = mm_q;
    eq_d    = eq_q;
    fin     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d   = '0;
        idx_d   = '0;
        mm_d    = FL_C;
        eq_d    = 1'b0;
      end
      RUN: if (bit_valid) begin
        cnt_d   = cnt_q + CNT_W'(m);
        idx_d   = idx_q + CNT_W'(1);
        mm_d    = (!m && mm_q == FL_C) ? idx_q : mm_q;
`ifdef SERIAL_EQ_EARLY_ABORT_EN
        fin     = (idx_q == LAST_C) || !m;
`else
        fin     = idx_q == LAST_C;
`endif
        state_d = fin ? DONE : RUN;
        eq_d    = fin ? (cnt_d == FL_C) : eq_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and result registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mm_q    <= '0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mm_q    <= mm_d;
      eq_q    <= eq_d;
    end
  end
endmodule

// File: tb/tb_serial_eq_checker.sv
// tb_serial_eq_checker: directed self-checking bench for serial_eq_checker (FRAME_LEN=8)
module tb_serial_eq_checker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_a = 1'b0;
  logic       bit_b = 1'b0;
  logic       bit_ready, busy, done, equal;
  logic [3:0] match_cnt, mismatch_idx;
  int         pass = 0;
  int         total = 0;

  serial_eq_checker #(.FRAME_LEN(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bit_valid(bit_valid),
    .bit_a(bit_a),
    .bit_b(bit_b),
    .bit_ready(bit_ready),
    .busy(busy),
    .done(done),
    .equal(equal),
    .match_cnt(match_cnt),
    .mismatch_idx(mismatch_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame MSB first; off = cycles between the final-beat edge and the edge after which done is seen (0 = next cycle)
  task automatic drive_frame(input logic [7:0] a, input logic [7:0] b, input int stall_at, input int stall_len,
                             input logic hold_start, output int beats, output int off, output int ndone,
                             output logic eq_o, output logic [3:0] cnt_o, output logic [3:0] idx_o);
    int stalled, lb, after;
    logic acc;
    beats = 0; off = -1; ndone = 0; stalled = 0; lb = -100; after = -1;
    eq_o = 1'b0; cnt_o = '0; idx_o = '0;
    start = 1'b1;
    tick();
    start = hold_start;
    for (int c = 0; c < 60; c++) begin
      bit_valid = 1'b0;
      if (bit_ready && beats < 8) begin
        if (beats == stall_at && stalled < stall_len) stalled++;
        else begin
          bit_valid = 1'b1;
          bit_a = a[7-beats];
          bit_b = b[7-beats];
        end
      end
      acc = bit_valid && bit_ready;
      tick();
      if (acc) begin
        beats++;
        lb = c;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          off = c - lb;
          eq_o = equal;
          cnt_o = match_cnt;
          idx_o = mismatch_idx;
          after = c;
        end
      end
      if (after >= 0 && c == after + 1) start = 1'b0;
      if (after >= 0 && c >= after + 4) break;
    end
    bit_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (bit_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bit_ready); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass++;
    total++; if (equal !== 1'b0) $display("FAIL reset_equal got %b want 0", equal); else pass++;
    total++; if (match_cnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", match_cnt); else pass++;
    total++; if (mismatch_idx !== 4'd0) $display("FAIL reset_idx got %0d want 0", mismatch_idx); else pass++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_matched();
    int beats, off, ndone;
    logic eq;
    logic [3:0] cnt, idx;
    drive_frame(8'b10110010, 8'b10110010, -1, 0, 1'b0, beats, off, ndone, eq, cnt, idx);
    total++; if (beats !== 8) $display("FAIL match_beats got %0d want 8", beats); else pass++;
    total++; if (off !== 0) $display("FAIL match_done_offset got %0d want 0", off); else pass++;
    total++; if (ndone !== 1) $display("FAIL match_ndone got %0d want 1", ndone); else pass++;
    total++; if (eq !== 1'b1) $display("FAIL match_equal got %b want 1", eq); else pass++;
    total++; if (cnt !== 4'd8) $display("FAIL match_cnt got %0d want 8", cnt); else pass++;
    total++; if (idx !== 4'd8) $display("FAIL match_idx got %0d want 8", idx); else pass++;
    total++; if (equal !== 1'b1 || match_cnt !== 4'd8) $display("FAIL match_hold got eq=%b cnt=%0d want eq=1 cnt=8", equal, match_cnt); else pass++;
  endtask

  task automatic test_mismatch(input int stall_at, input int stall_len, input string tag);
    int beats, off, ndone;
    logic eq;
    logic [3:0] cnt, idx;
`ifdef SERIAL_EQ_EARLY_ABORT_EN
    int exp_beats = 4;
    logic [3:0] exp_cnt = 4'd3;
`else
    int exp_beats = 8;
    logic [3:0] exp_cnt = 4'd6;
`endif
    drive_frame(8'b10110010, 8'b10100011, stall_at, stall_len, 1'b0, beats, off, ndone, eq, cnt, idx);
    total++; if (beats !== exp_beats) $display("FAIL %s_beats got %0d want %0d", tag, beats, exp_beats); else pass++;
    total++; if (off !== 0) $display("FAIL %s_done_offset got %0d want 0", tag, off); else pass++;
    total++; if (ndone !== 1) $display("FAIL %s_ndone got %0d want 1", tag, ndone); else pass++;
    total++; if (eq !== 1'b0) $display("FAIL %s_equal got %b want 0", tag, eq); else pass++;
    total++; if (cnt !== exp_cnt) $display("FAIL %s_cnt got %0d want %0d", tag, cnt, exp_cnt); else pass++;
    total++; if (idx !== 4'd3) $display("FAIL %s_idx got %0d want 3", tag, idx); else pass++;
  endtask

  task automatic test_reset_mid_frame();
    int beats, off, ndone, seen;
    logic eq;
    logic [3:0] cnt, idx;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_a = 1'b1;
      bit_b = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    total++; if (busy !== 1'b1 || mismatch_idx !== 4'd8 || match_cnt !== 4'd4) $display("FAIL rstmid_pre got busy=%b idx=%0d cnt=%0d want busy=1 idx=8 cnt=4", busy, mismatch_idx, match_cnt); else pass++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || bit_ready !== 1'b0) $display("FAIL rstmid_ctl got busy=%b ready=%b want 0 0", busy, bit_ready); else pass++;
    total++; if (match_cnt !== 4'd0 || mismatch_idx !== 4'd0 || equal !== 1'b0) $display("FAIL rstmid_res got cnt=%0d idx=%0d eq=%b want 0 0 0", match_cnt, mismatch_idx, equal); else pass++;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) seen++;
    end
    total++; if (seen !== 0) $display("FAIL rstmid_no_done got %0d want 0", seen); else pass++;
    drive_frame(8'b01011100, 8'b01011100, -1, 0, 1'b0, beats, off, ndone, eq, cnt, idx);
    total++; if (beats !== 8 || off !== 0 || ndone !== 1) $display("FAIL rstmid_clean_timing got beats=%0d off=%0d ndone=%0d want 8 0 1", beats, off, ndone); else pass++;
    total++; if (eq !== 1'b1 || cnt !== 4'd8 || idx !== 4'd8) $display("FAIL rstmid_clean_res got eq=%b cnt=%0d idx=%0d want 1 8 8", eq, cnt, idx); else pass++;
  endtask

  task automatic test_ignored_start();
    int beats, off, ndone;
    logic eq;
    logic [3:0] cnt, idx;
    drive_frame(8'b00001111, 8'b00011111, -1, 0, 1'b1, beats, off, ndone, eq, cnt, idx);
    total++; if (ndone !== 1) $display("FAIL ignstart_ndone got %0d want 1", ndone); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL ignstart_idle got busy=%b want 0", busy); else pass++;
`ifdef SERIAL_EQ_EARLY_ABORT_EN
    total++; if (beats !== 4 || cnt !== 4'd3 || idx !== 4'd3) $display("FAIL ignstart_res got beats=%0d cnt=%0d idx=%0d want 4 3 3", beats, cnt, idx); else pass++;
`else
    total++; if (beats !== 8 || cnt !== 4'd7 || idx !== 4'd3) $display("FAIL ignstart_res got beats=%0d cnt=%0d idx=%0d want 8 7 3", beats, cnt, idx); else pass++;
`endif
    total++; if (off !== 0 || eq !== 1'b0) $display("FAIL ignstart_done got off=%0d eq=%b want 0 0", off, eq); else pass++;
  endtask

  task automatic test_early_abort();
    int beats, off, ndone;
    logic eq;
    logic [3:0] cnt, idx;
`ifdef SERIAL_EQ_EARLY_ABORT_EN
    int exp_beats = 3;
    logic [3:0] exp_cnt = 4'd2;
`else
    int exp_beats = 8;
    logic [3:0] exp_cnt = 4'd7;
`endif
    drive_frame(8'b11111111, 8'b11011111, -1, 0, 1'b0, beats, off, ndone, eq, cnt, idx);
    total++; if (beats !== exp_beats) $display("FAIL abort_beats got %0d want %0d", beats, exp_beats); else pass++;
    total++; if (off !== 0 || ndone !== 1) $display("FAIL abort_done got off=%0d ndone=%0d want 0 1", off, ndone); else pass++;
    total++; if (eq !== 1'b0) $display("FAIL abort_equal got %b want 0", eq); else pass++;
    total++; if (cnt !== exp_cnt) $display("FAIL abort_cnt got %0d want %0d", cnt, exp_cnt); else pass++;
    total++; if (idx !== 4'd2) $display("FAIL abort_idx got %0d want 2", idx); else pass++;
  endtask

  initial begin
    test_reset();
    test_matched();
    test_mismatch(-1, 0, "mismatch");
    test_mismatch(2, 3, "stall");
    test_reset_mid_frame();
    test_ignored_start();
    test_early_abort();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
